vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Upstream stage of the line renderer.
- Free-running horizontal/vertical counters produce the X_VGA/Y_VGA scan coordinates consumed by the line-draw stage.
- Accepts that stage's RGB back, delays sync/blank to match its pipeline latency, and drives the VGA connector with blanked colour and sync.
- Default timing is 640x480@60 on a 25.175 MHz pixel clock.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, sync active level (0 = active-low)
- PIPE_DELAY, 1, clocks from X_VGA/Y_VGA to the matching RGB_IN (0..7)

Ports:
- VGA_CLK  in  1  pixel clock; all logic on rising edge
- RST  in  1  asynchronous active-high reset
- X_VGA  out  11  signed; horizontal counter, 0..H_TOTAL-1
- Y_VGA  out  11  signed; vertical counter, 0..V_TOTAL-1
- ACTIVE  out  1  undelayed; high when X_VGA<H_ACTIVE and Y_VGA<V_ACTIVE
- FRAME_START  out  1  one-clock pulse when X_VGA=0 and Y_VGA=0, undelayed
- RGB_IN  in  12  {R,G,B} 4 bits each, from line-draw stage
- VGA_HS  out  1  horizontal sync, aligned with colour outputs
- VGA_VS  out  1  vertical sync, aligned with colour outputs
- VGA_R, VGA_G, VGA_B  out  4 each  blanked colour to DAC

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- On RST high, asynchronous, all outputs and pipeline stages go to reset values:
  - X_VGA=0, Y_VGA=0, ACTIVE=0, FRAME_START=0.
  - VGA_HS=VGA_VS=inactive level (!SYNC_POL).
  - VGA_R/G/B=0.
  - Horizontal FSM=H_ACT.
- First clock after RST deasserts:
  - Counters hold 0 and FRAME_START=1.
  - Counting starts on the following edge.
- Horizontal counter X:
  - Increments every clock.
  - At H_TOTAL-1 wraps to 0 and increments Y.
- Vertical counter Y:
  - At V_TOTAL-1 with X wrapping, Y wraps to 0.
- Horizontal FSM states: H_ACT -> H_FP -> H_SYNC -> H_BP -> H_ACT.
  - Transitions happen when X equals the last count of each region: H_ACTIVE-1, H_ACTIVE+H_FP-1, H_ACTIVE+H_FP+H_SYNC-1, H_TOTAL-1.
  - FSM state and X must stay consistent; an assertion checks this.
- Vertical region decode is from Y by comparison; no separate FSM.
- Raw hsync: active when H_ACTIVE+H_FP <= X < H_ACTIVE+H_FP+H_SYNC.
- Raw vsync: active when V_ACTIVE+V_FP <= Y < V_ACTIVE+V_FP+V_SYNC, for the entire line including its blanking.
- ACTIVE and FRAME_START are combinational from the registered counters, so they share the X/Y cycle.
- Alignment: raw hsync, raw vsync and ACTIVE pass through a PIPE_DELAY-stage shift register.
  - If X_VGA/Y_VGA show pixel p at cycle t, RGB_IN for p arrives at t+PIPE_DELAY.
  - VGA_HS/VGA_VS/VGA_R/G/B for p are registered and visible at t+PIPE_DELAY+1.
  - PIPE_DELAY=0 means no shift stages; only the output register remains.
- Blanking: when the delayed ACTIVE is 0, VGA_R/G/B=0 regardless of RGB_IN.
- RST asserted mid-frame: everything returns to reset values immediately, including the shift register (no stale sync). Scan restarts at (0,0) with a fresh FRAME_START.
- Counter width: 11 bits signed, MSB always 0 for legal parameters. Elaboration check: H_TOTAL and V_TOTAL <= 1023.

Decomposition:
- Shared package vga_pkg holds the 640x480 timing constants, the H-state encoding (H_ACT, H_FP, H_SYNC, H_BP, 2-bit) and the RGB field slice constants.
- One natural sub-module: vga_delay_line (parameterised width and depth shift register with async reset). It is instantiated once for the {hs, vs, active} bundle.

Test Plan:
- Reset then release, default params -> FRAME_START high for exactly one clock at X=0,Y=0, then first hsync (low) at X=656. No FRAME_START again for 800*525=420000 clocks.
- Count one line -> X runs 0..799 and wraps. Y increments exactly at the wrap. Raw hsync low for 96 clocks, X=656..751. ACTIVE high for 640 clocks.
- Full frame -> VGA_VS low for exactly 2 lines (Y=490,491, i.e. 1600 clocks). Y wraps 524->0. FRAME_START re-pulses.
- PIPE_DELAY=1, RGB_IN=12'hFFF constant -> VGA_R/G/B=4'hF from 2 clocks after X=0 on active lines. Output is 0 from 2 clocks after X=640 through the blank interval. VGA_HS falls 2 clocks after X=656.
- PIPE_DELAY=0 and PIPE_DELAY=3 -> sync/colour edges shift to 1 and 4 clocks after the counter event respectively.
- Assert RST at X=300,Y=200 for 3 clocks -> outputs reset asynchronously within the same cycle. The shift register is cleared, so no stray sync pulse. Scan restarts at (0,0) with FRAME_START.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared timing constants, horizontal state encoding and RGB field slices
// for the VGA scan generator. Defaults describe 640x480@60 at 25.175 MHz.
package vga_pkg;

  // 640x480@60 horizontal timing, in pixel clocks
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;

  // 640x480@60 vertical timing, in lines
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Counters are 11 bits; totals must stay below 1024 so the MSB is always 0
  localparam int CNT_W     = 11;
  localparam int MAX_TOTAL = 1023;

  // Horizontal region the scan is currently in
  typedef enum logic [1:0] {
    H_ACT    = 2'd0,
    H_FPORCH = 2'd1,
    H_SPULSE = 2'd2,
    H_BPORCH = 2'd3
  } h_state_t;

  // {R,G,B} nibble positions in the 12-bit colour word
  localparam int R_MSB = 11;
  localparam int R_LSB = 8;
  localparam int G_MSB = 7;
  localparam int G_LSB = 4;
  localparam int B_MSB = 3;
  localparam int B_LSB = 0;

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with asynchronous clear for sideband bits.
// DEPTH=0 is a plain wire; otherwise the output lags the input by DEPTH clocks.
// Clearing on reset guarantees no stale values escape after a mid-stream reset.
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] delayed
);

  generate
    if (DEPTH == 0) begin : g_bypass
      // Clock and reset have no role without storage
      logic unused_ok;
      assign unused_ok = &{1'b0, clk, rst};
      assign delayed   = data;
    end else begin : g_shift
      logic [WIDTH-1:0] stage [DEPTH];

      // Shift one position per clock, cleared asynchronously
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
          stage[0] <= data;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign delayed = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA scan generator: free-running X/Y counters, sync/blank delayed to meet the
// line-draw stage's RGB, registered blanked colour and sync to the DAC.
// Latency: X/Y to connector is PIPE_DELAY+1 clocks; no backpressure, free-running.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter bit SYNC_POL   = 1'b0,
  parameter int PIPE_DELAY = 1
) (
  input  logic              VGA_CLK,
  input  logic              RST,
  output logic signed [10:0] X_VGA,
  output logic signed [10:0] Y_VGA,
  output logic              ACTIVE,
  output logic              FRAME_START,
  input  logic [11:0]       RGB_IN,
  output logic              VGA_HS,
  output logic              VGA_VS,
  output logic [3:0]        VGA_R,
  output logic [3:0]        VGA_G,
  output logic [3:0]        VGA_B
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Region boundaries as counter-width constants
  localparam logic [CNT_W-1:0] H_ACT_LIM   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START    = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END      = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] H_ACT_LAST  = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] H_FP_LAST   = CNT_W'(H_ACTIVE + H_FP - 1);
  localparam logic [CNT_W-1:0] H_SYNC_LAST = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] H_LAST      = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_ACT_LIM   = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] VS_START    = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END      = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] V_LAST      = CNT_W'(V_TOTAL - 1);

  generate
    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_total
      $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1023");
    end
    if (PIPE_DELAY < 0 || PIPE_DELAY > 7) begin : g_bad_delay
      $error("vga_timing_gen: PIPE_DELAY must be 0..7");
    end
  endgenerate

  logic [CNT_W-1:0] x_cnt;
  logic [CNT_W-1:0] y_cnt;
  logic             running;   // low for the first clock after reset so (0,0) is held once
  h_state_t         h_state;
  h_state_t         h_next;
  h_state_t         h_expect;
  logic             hs_raw;
  logic             vs_raw;
  logic             act_raw;
  logic             hs_dly;
  logic             vs_dly;
  logic             act_dly;

  // Scan counters: hold (0,0) for one clock after reset, then free-run
  always_ff @(posedge VGA_CLK or posedge RST) begin
    if (RST) begin
      x_cnt   <= '0;
      y_cnt   <= '0;
      running <= 1'b0;
    end else if (!running) begin
      running <= 1'b1;
    end else if (x_cnt == H_LAST) begin
      x_cnt <= '0;
      y_cnt <= (y_cnt == V_LAST) ? '0 : y_cnt + 1'b1;
    end else begin
      x_cnt <= x_cnt + 1'b1;
    end
  end

  // Horizontal region state register
  always_ff @(posedge VGA_CLK or posedge RST) begin
    if (RST) h_state <= H_ACT;
    else     h_state <= h_next;
  end

  // Advance the region on the last count of each region, only while counting
  always_comb begin
    h_next = h_state;
    if (running) begin
      case (h_state)
        H_ACT:    if (x_cnt == H_ACT_LAST)  h_next = H_FPORCH;
        H_FPORCH: if (x_cnt == H_FP_LAST)   h_next = H_SPULSE;
        H_SPULSE: if (x_cnt == H_SYNC_LAST) h_next = H_BPORCH;
        H_BPORCH: if (x_cnt == H_LAST)      h_next = H_ACT;
        default:                            h_next = H_ACT;
      endcase
    end
  end

  // Region implied by X alone, used to cross-check the state register
  always_comb begin
    h_expect = H_BPORCH;
    if (x_cnt < H_ACT_LIM)   h_expect = H_ACT;
    else if (x_cnt < HS_START) h_expect = H_FPORCH;
    else if (x_cnt < HS_END)   h_expect = H_SPULSE;
  end

  a_h_state_consistent: assert property (@(posedge VGA_CLK) disable iff (RST) h_state == h_expect);

  assign hs_raw  = (h_state == H_SPULSE);
  assign vs_raw  = (y_cnt >= VS_START) && (y_cnt < VS_END);
  assign act_raw = running && (x_cnt < H_ACT_LIM) && (y_cnt < V_ACT_LIM);

  assign X_VGA       = x_cnt;
  assign Y_VGA       = y_cnt;
  assign ACTIVE      = act_raw;
  assign FRAME_START = running && (x_cnt == '0) && (y_cnt == '0);

  vga_delay_line #(
    .WIDTH (3),
    .DEPTH (PIPE_DELAY)
  ) u_sync_dly (
    .clk     (VGA_CLK),
    .rst     (RST),
    .data    ({hs_raw, vs_raw, act_raw}),
    .delayed ({hs_dly, vs_dly, act_dly})
  );

  // Output register: apply sync polarity and blank colour outside the active area
  always_ff @(posedge VGA_CLK or posedge RST) begin
    if (RST) begin
      VGA_HS <= ~SYNC_POL;
      VGA_VS <= ~SYNC_POL;
      VGA_R  <= '0;
      VGA_G  <= '0;
      VGA_B  <= '0;
    end else begin
      VGA_HS <= hs_dly ? SYNC_POL : ~SYNC_POL;
      VGA_VS <= vs_dly ? SYNC_POL : ~SYNC_POL;
      VGA_R  <= act_dly ? RGB_IN[R_MSB:R_LSB] : 4'h0;
      VGA_G  <= act_dly ? RGB_IN[G_MSB:G_LSB] : 4'h0;
      VGA_B  <= act_dly ? RGB_IN[B_MSB:B_LSB] : 4'h0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three reduced-timing instances (PIPE_DELAY 0/1/3)
// and one default 640x480 instance share clock, reset and RGB input.
// Expected values come from a frame-position arithmetic model of the scan.
module tb_vga_timing_gen;

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb;
  } tim_t;

  localparam int SM_HT    = 16 + 4 + 6 + 5;
  localparam int SM_VT    = 8 + 2 + 2 + 3;
  localparam int SM_FRAME = SM_HT * SM_VT;
  localparam logic [37:0] RST_OBS = {22'd0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] rgb = 12'h000;
  bit          rgb_white = 1'b0;

  logic signed [10:0] x_v [4];
  logic signed [10:0] y_v [4];
  logic act_v [4], fs_v [4], hs_v [4], vs_v [4];
  logic [3:0] r_v [4], g_v [4], b_v [4];

  int total = 0;
  int bad   = 0;
  int k     = -1;              // clocks since the first edge after reset release
  logic [11:0] rgb_hist [16];  // RGB presented during cycle n, at index n&15
  int   dly [3] = '{0, 1, 3};
  tim_t sm, df;

  always #5 clk = ~clk;

  vga_timing_gen #(.H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(5), .V_ACTIVE(8), .V_FP(2),
                   .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b0), .PIPE_DELAY(0)) u_d0 (
    .VGA_CLK(clk), .RST(rst), .X_VGA(x_v[0]), .Y_VGA(y_v[0]), .ACTIVE(act_v[0]),
    .FRAME_START(fs_v[0]), .RGB_IN(rgb), .VGA_HS(hs_v[0]), .VGA_VS(vs_v[0]),
    .VGA_R(r_v[0]), .VGA_G(g_v[0]), .VGA_B(b_v[0]));

  vga_timing_gen #(.H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(5), .V_ACTIVE(8), .V_FP(2),
                   .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b0), .PIPE_DELAY(1)) u_d1 (
    .VGA_CLK(clk), .RST(rst), .X_VGA(x_v[1]), .Y_VGA(y_v[1]), .ACTIVE(act_v[1]),
    .FRAME_START(fs_v[1]), .RGB_IN(rgb), .VGA_HS(hs_v[1]), .VGA_VS(vs_v[1]),
    .VGA_R(r_v[1]), .VGA_G(g_v[1]), .VGA_B(b_v[1]));

  vga_timing_gen #(.H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(5), .V_ACTIVE(8), .V_FP(2),
                   .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b0), .PIPE_DELAY(3)) u_d3 (
    .VGA_CLK(clk), .RST(rst), .X_VGA(x_v[2]), .Y_VGA(y_v[2]), .ACTIVE(act_v[2]),
    .FRAME_START(fs_v[2]), .RGB_IN(rgb), .VGA_HS(hs_v[2]), .VGA_VS(vs_v[2]),
    .VGA_R(r_v[2]), .VGA_G(g_v[2]), .VGA_B(b_v[2]));

  vga_timing_gen u_def (
    .VGA_CLK(clk), .RST(rst), .X_VGA(x_v[3]), .Y_VGA(y_v[3]), .ACTIVE(act_v[3]),
    .FRAME_START(fs_v[3]), .RGB_IN(rgb), .VGA_HS(hs_v[3]), .VGA_VS(vs_v[3]),
    .VGA_R(r_v[3]), .VGA_G(g_v[3]), .VGA_B(b_v[3]));

  // Observed outputs of instance i: {X, Y, ACTIVE, FRAME_START, HS, VS, R, G, B}
  function automatic logic [37:0] obs(input int i);
    return {x_v[i], y_v[i], act_v[i], fs_v[i], hs_v[i], vs_v[i], r_v[i], g_v[i], b_v[i]};
  endfunction

  // Model of the undelayed outputs k clocks after scanning starts: {X, Y, ACTIVE, FRAME_START}
  function automatic logic [23:0] m_cnt(input int kk, input tim_t t);
    int ht, vt, n, x, y;
    if (kk < 0) return 24'd0;
    ht = t.ha + t.hf + t.hs + t.hb;
    vt = t.va + t.vf + t.vs + t.vb;
    n  = kk % (ht * vt);
    x  = n % ht;
    y  = n / ht;
    return {11'(x), 11'(y), (x < t.ha) && (y < t.va), n == 0};
  endfunction

  // Model of the connector outputs: pixel shown at counters k-d-1 reaches the pins now
  function automatic logic [13:0] m_vga(input int kk, input int d, input tim_t t, input logic [11:0] c);
    int ht, vt, p, x, y;
    logic hsync, vsync, act;
    p = kk - d - 1;
    if (p < 0) return {2'b11, 12'h000};
    ht = t.ha + t.hf + t.hs + t.hb;
    vt = t.va + t.vf + t.vs + t.vb;
    x  = p % ht;
    y  = (p / ht) % vt;
    hsync = (x >= t.ha + t.hf) && (x < t.ha + t.hf + t.hs);
    vsync = (y >= t.va + t.vf) && (y < t.va + t.vf + t.vs);
    act   = (x < t.ha) && (y < t.va);
    return {~hsync, ~vsync, act ? c : 12'h000};
  endfunction

  // Present this cycle's RGB, then advance one clock and stop at the sampling edge
  task automatic step();
    rgb = rgb_white ? 12'hFFF : 12'($urandom);
    rgb_hist[k & 15] = rgb;
    @(posedge clk);
    k++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    k = -1;
  endtask

  task automatic test_reset();
    rgb = 12'hFFF;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (obs(i) !== RST_OBS) begin
        bad++;
        $display("FAIL reset_values inst=%0d got=%h exp=%h", i, obs(i), RST_OBS);
      end
    end
    rst = 1'b0;
    k = -1;
    #1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (obs(i) !== RST_OBS) begin
        bad++;
        $display("FAIL prestart inst=%0d got=%h exp=%h", i, obs(i), RST_OBS);
      end
    end
    for (int n = 0; n < 2; n++) begin
      step();
      for (int i = 0; i < 4; i++) begin
        total++;
        if ({x_v[i], y_v[i], fs_v[i]} !== {11'(k), 11'd0, k == 0}) begin
          bad++;
          $display("FAIL first_clocks inst=%0d k=%0d got x=%0d y=%0d fs=%b", i, k, x_v[i], y_v[i], fs_v[i]);
        end
      end
    end
  endtask

  task automatic test_default_line();
    int nhs, nact, nfs, first_low;
    logic [23:0] ec;
    logic [13:0] ev;
    nhs = 0; nact = 0; nfs = 0; first_low = -1;
    rgb_white = 1'b0;
    do_reset();
    for (int n = 0; n < 810; n++) begin
      step();
      ec = m_cnt(k, df);
      ev = m_vga(k, 1, df, rgb_hist[(k - 1) & 15]);
      total++;
      if (obs(3) !== {ec, ev}) begin
        bad++;
        $display("FAIL default_scan k=%0d got=%h exp=%h", k, obs(3), {ec, ev});
      end
      if (!hs_v[3]) begin
        nhs++;
        if (first_low < 0) first_low = k;
      end
      if (k < 800 && act_v[3]) nact++;
      if (fs_v[3]) nfs++;
    end
    total++;
    if (first_low !== 658) begin
      bad++;
      $display("FAIL default_first_hsync got=%0d exp=658", first_low);
    end
    total++;
    if (nhs !== 96) begin
      bad++;
      $display("FAIL default_hsync_width got=%0d exp=96", nhs);
    end
    total++;
    if (nact !== 640) begin
      bad++;
      $display("FAIL default_active_count got=%0d exp=640", nact);
    end
    total++;
    if (nfs !== 1) begin
      bad++;
      $display("FAIL default_frame_start_count got=%0d exp=1", nfs);
    end
  endtask

  task automatic test_random_scan();
    int nvs, nfs;
    logic [23:0] ec;
    logic [13:0] ev;
    nvs = 0; nfs = 0;
    rgb_white = 1'b0;
    do_reset();
    for (int n = 0; n < 2 * SM_FRAME + 10; n++) begin
      step();
      ec = m_cnt(k, sm);
      for (int i = 0; i < 3; i++) begin
        ev = m_vga(k, dly[i], sm, rgb_hist[(k - 1) & 15]);
        total++;
        if (obs(i) !== {ec, ev}) begin
          bad++;
          $display("FAIL scan inst=%0d k=%0d got=%h exp=%h", i, k, obs(i), {ec, ev});
        end
      end
      if (k < SM_FRAME && !vs_v[1]) nvs++;
      if (fs_v[1]) nfs++;
    end
    total++;
    if (nvs !== 2 * SM_HT) begin
      bad++;
      $display("FAIL vsync_width got=%0d exp=%0d", nvs, 2 * SM_HT);
    end
    total++;
    if (nfs !== 3) begin
      bad++;
      $display("FAIL frame_start_count got=%0d exp=3", nfs);
    end
  endtask

  task automatic test_white_align();
    logic [37:0] o;
    rgb_white = 1'b1;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      step();
      for (int i = 0; i < 3; i++) begin
        o = obs(i);
        if (k == dly[i] || k == dly[i] + 17) begin
          total++;
          if (o[11:0] !== 12'h000) begin
            bad++;
            $display("FAIL white_blank inst=%0d k=%0d got=%h exp=000", i, k, o[11:0]);
          end
        end
        if (k == dly[i] + 1 || k == dly[i] + 16) begin
          total++;
          if (o[11:0] !== 12'hFFF) begin
            bad++;
            $display("FAIL white_pixel inst=%0d k=%0d got=%h exp=fff", i, k, o[11:0]);
          end
        end
        if (k == dly[i] + 20 || k == dly[i] + 21) begin
          total++;
          if (o[13] !== (k == dly[i] + 20)) begin
            bad++;
            $display("FAIL hsync_edge inst=%0d k=%0d got=%b exp=%b", i, k, o[13], k == dly[i] + 20);
          end
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [23:0] ec;
    logic [13:0] ev;
    rgb_white = 1'b0;
    do_reset();
    for (int n = 0; n < 5 * SM_HT + 22; n++) step();
    total++;
    if ({x_v[1], y_v[1]} !== {11'd21, 11'd5}) begin
      bad++;
      $display("FAIL mid_reset_position got x=%0d y=%0d exp x=21 y=5", x_v[1], y_v[1]);
    end
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (obs(i) !== RST_OBS) begin
        bad++;
        $display("FAIL async_reset inst=%0d got=%h exp=%h", i, obs(i), RST_OBS);
      end
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        total++;
        if (obs(i) !== RST_OBS) begin
          bad++;
          $display("FAIL reset_hold inst=%0d c=%0d got=%h exp=%h", i, c, obs(i), RST_OBS);
        end
      end
    end
    rst = 1'b0;
    k = -1;
    for (int n = 0; n < 40; n++) begin
      step();
      ec = m_cnt(k, sm);
      for (int i = 0; i < 3; i++) begin
        ev = m_vga(k, dly[i], sm, rgb_hist[(k - 1) & 15]);
        total++;
        if (obs(i) !== {ec, ev}) begin
          bad++;
          $display("FAIL restart inst=%0d k=%0d got=%h exp=%h", i, k, obs(i), {ec, ev});
        end
      end
    end
  endtask

  initial begin
    sm = '{16, 4, 6, 5, 8, 2, 2, 3};
    df = '{640, 16, 96, 48, 480, 10, 2, 33};
    for (int i = 0; i < 16; i++) rgb_hist[i] = 12'h000;
    test_reset();
    test_default_line();
    test_random_scan();
    test_white_align();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
